// File: rtl/run_ctrl_pkg.sv
// Shared types for the multi-core run controller: FSM state and fail-cause codes.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_WDOG    = 2'd1,
    CAUSE_OVERRUN = 2'd2
  } fail_cause_t;

endpackage

// File: rtl/core_budget_counter.sv
// Per-core fetch/retire bookkeeping against the shared instruction budget.
// The fetch enable drops the cycle after the fetch that reaches the budget;
// retires beyond the budget are flagged as overrun and never counted.
module core_budget_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable_init,
  input  logic             active,
  input  logic             stop,
  input  logic [CNT_W-1:0] budget,
  input  logic             fetch,
  input  logic             retire,
  output logic             enable,
  output logic             retired_all,
  output logic             overrun
);

  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] fetch_nxt;
  logic             fetch_hit;

  assign fetch_hit   = enable & fetch;
  assign fetch_nxt   = fetch_cnt + 1'b1;
  assign retired_all = (retire_cnt == budget);
  assign overrun     = active & retire & retired_all;

  // Counter and enable registers; clear restarts a run with a fresh budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      retire_cnt <= '0;
      enable     <= 1'b0;
    end else if (clear) begin
      fetch_cnt  <= '0;
      retire_cnt <= '0;
      enable     <= enable_init;
    end else begin
      if (fetch_hit) fetch_cnt <= fetch_nxt;
      if (stop) enable <= 1'b0;
      else if (fetch_hit && (fetch_nxt == budget)) enable <= 1'b0;
      if (active && retire && !retired_all) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_core_run_control.sv
// Run controller for a group of lockstep cores: hands out a per-core
// instruction budget, drains outstanding retires, and aborts on watchdog
// timeout or retire overrun.
//
// state    | meaning
// IDLE     | out of reset, waiting for start
// RUN      | cores fetching; leaves when every enable has dropped
// DRAIN    | fetch finished, waiting for all retires to reach budget
// DONE     | every core retired exactly the budget (finished sticky)
// FAIL     | watchdog or overrun abort (fail and cause sticky)
module multi_core_run_control
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES   = 2,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     max_instr_i,
  input  logic [NUM_CORES-1:0] fetch_i,
  input  logic [NUM_CORES-1:0] retire_i,
  output logic [NUM_CORES-1:0] enable_o,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic                 fail_o,
  output logic [1:0]           fail_cause_o
);

  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  run_state_t       state, state_n;
  fail_cause_t      cause, cause_n;
  logic [CNT_W-1:0] budget;
  logic [WDOG_W-1:0] wdog;
  logic             finished, fail;
  logic             start_acc, active, wdog_exp, any_overrun;
  logic [NUM_CORES-1:0] retired_all, overrun;

  assign active      = (state == ST_RUN) || (state == ST_DRAIN);
  assign any_overrun = |overrun;
  assign wdog_exp    = active && (wdog == WDOG_W'(1)) && !(|retire_i);

  // Next-state logic; overrun outranks the watchdog when both hit together.
  always_comb begin
    state_n   = state;
    cause_n   = CAUSE_NONE;
    start_acc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_n   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (any_overrun) begin
          state_n = ST_FAIL;
          cause_n = CAUSE_OVERRUN;
        end else if (wdog_exp) begin
          state_n = ST_FAIL;
          cause_n = CAUSE_WDOG;
        end else if (!(|enable_o)) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (any_overrun) begin
          state_n = ST_FAIL;
          cause_n = CAUSE_OVERRUN;
        end else if (&retired_all) begin
          state_n = ST_DONE;
        end else if (wdog_exp) begin
          state_n = ST_FAIL;
          cause_n = CAUSE_WDOG;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, budget, sticky status and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      budget   <= '0;
      finished <= 1'b0;
      fail     <= 1'b0;
      cause    <= CAUSE_NONE;
      wdog     <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        budget   <= max_instr_i;
        finished <= 1'b0;
        fail     <= 1'b0;
        cause    <= CAUSE_NONE;
        wdog     <= WDOG_W'(WDOG_CYCLES);
      end else begin
        if (state_n == ST_FAIL && state != ST_FAIL) begin
          fail  <= 1'b1;
          cause <= cause_n;
        end
        if (state_n == ST_DONE && state != ST_DONE) finished <= 1'b1;
        if (active) begin
          if ((|retire_i) || (state_n != state)) wdog <= WDOG_W'(WDOG_CYCLES);
          else wdog <= wdog - 1'b1;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    core_budget_counter #(.CNT_W(CNT_W)) u_core (
      .clk         (clk_i),
      .rst         (rst_i),
      .clear       (start_acc),
      .enable_init (|max_instr_i),
      .active      (active),
      .stop        (state_n == ST_FAIL || state_n == ST_DONE),
      .budget      (budget),
      .fetch       (fetch_i[c]),
      .retire      (retire_i[c]),
      .enable      (enable_o[c]),
      .retired_all (retired_all[c]),
      .overrun     (overrun[c])
    );
  end

  assign busy_o       = active;
  assign finished_o   = finished;
  assign fail_o       = fail;
  assign fail_cause_o = cause;

endmodule

// File: tb/tb_multi_core_run_control.sv
// Directed bench for multi_core_run_control (2 cores, 8-cycle watchdog).
module tb_multi_core_run_control;

  localparam int NC = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [CW-1:0] max_instr;
  logic [NC-1:0] fetch, retire;
  logic [NC-1:0] enable;
  logic          busy, finished, fail;
  logic [1:0]    cause;

  int vectors = 0;
  int miscompares = 0;

  multi_core_run_control #(.NUM_CORES(NC), .CNT_W(CW), .WDOG_CYCLES(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .max_instr_i  (max_instr),
    .fetch_i      (fetch),
    .retire_i     (retire),
    .enable_o     (enable),
    .busy_o       (busy),
    .finished_o   (finished),
    .fail_o       (fail),
    .fail_cause_o (cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; max_instr = '0; fetch = '0; retire = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_enable", 32'(enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_finished", 32'(finished), 32'h0);
    chk("rst_fail", 32'(fail), 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);

    // Budget 3, both cores fetch and retire together three times.
    max_instr = 3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy", 32'(busy), 32'h1);
    chk("a_enable_on", 32'(enable), 32'h3);
    fetch = 2'b11; retire = 2'b11;
    tick(); tick();
    chk("a_enable_mid", 32'(enable), 32'h3);
    tick();
    fetch = 2'b00; retire = 2'b00;
    chk("a_enable_off", 32'(enable), 32'h0);
    tick();
    chk("a_drain_busy", 32'(busy), 32'h1);
    chk("a_drain_fin", 32'(finished), 32'h0);
    tick();
    chk("a_finished", 32'(finished), 32'h1);
    chk("a_fail", 32'(fail), 32'h0);
    chk("a_idle_busy", 32'(busy), 32'h0);

    // Budget 4, core0 fetch held 10 cycles; a stray start mid-run is ignored.
    max_instr = 4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_fin_clear", 32'(finished), 32'h0);
    for (int i = 0; i < 10; i++) begin
      fetch  = 2'b01;
      retire = (i < 4) ? 2'b01 : 2'b00;
      start  = (i == 5);
      max_instr = (i == 5) ? 1 : 4;
      tick();
      chk($sformatf("b_en0_%0d", i + 1), 32'(enable[0]), (i < 3) ? 32'h1 : 32'h0);
    end
    start = 1'b0; max_instr = 4;
    chk("b_en1_still", 32'(enable[1]), 32'h1);
    fetch = 2'b10; retire = 2'b10;
    tick(); tick(); tick(); tick();
    fetch = 2'b00; retire = 2'b00;
    chk("b_enable_off", 32'(enable), 32'h0);
    chk("b_busy_run", 32'(busy), 32'h1);
    tick();
    chk("b_drain_fin", 32'(finished), 32'h0);
    tick();
    chk("b_finished", 32'(finished), 32'h1);
    chk("b_fail", 32'(fail), 32'h0);

    // Budget 2, core1 retires three times -> overrun.
    max_instr = 2; start = 1'b1;
    tick();
    start = 1'b0;
    retire = 2'b10;
    tick(); tick();
    chk("c_no_fail_yet", 32'(fail), 32'h0);
    tick();
    retire = 2'b00;
    chk("c_fail", 32'(fail), 32'h1);
    chk("c_cause", 32'(cause), 32'h2);
    chk("c_enable", 32'(enable), 32'h0);
    chk("c_busy", 32'(busy), 32'h0);

    // Budget 2, no retires -> watchdog 8 cycles after RUN entry.
    max_instr = 2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_fail_clear", 32'(fail), 32'h0);
    chk("d_cause_clear", 32'(cause), 32'h0);
    chk("d_enable_on", 32'(enable), 32'h3);
    for (int i = 0; i < 7; i++) tick();
    chk("d_no_fail_yet", 32'(fail), 32'h0);
    tick();
    chk("d_fail", 32'(fail), 32'h1);
    chk("d_cause", 32'(cause), 32'h1);
    chk("d_enable", 32'(enable), 32'h0);

    // Budget 0 -> RUN, DRAIN, DONE on consecutive cycles, enables never high.
    max_instr = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("e_run_busy", 32'(busy), 32'h1);
    chk("e_run_en", 32'(enable), 32'h0);
    tick();
    chk("e_drain_busy", 32'(busy), 32'h1);
    chk("e_drain_en", 32'(enable), 32'h0);
    chk("e_drain_fin", 32'(finished), 32'h0);
    tick();
    chk("e_finished", 32'(finished), 32'h1);
    chk("e_done_en", 32'(enable), 32'h0);

    // Reset during DRAIN (with start asserted), then a clean budget-1 run.
    max_instr = 2; start = 1'b1;
    tick();
    start = 1'b0;
    fetch = 2'b11; retire = 2'b01;
    tick();
    retire = 2'b00;
    tick();
    fetch = 2'b00;
    tick();
    chk("f_drain_busy", 32'(busy), 32'h1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("f_rst_busy", 32'(busy), 32'h0);
    chk("f_rst_en", 32'(enable), 32'h0);
    chk("f_rst_fail", 32'(fail), 32'h0);
    max_instr = 1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("f_enable_on", 32'(enable), 32'h3);
    fetch = 2'b11; retire = 2'b11;
    tick();
    fetch = 2'b00; retire = 2'b00;
    chk("f_enable_off", 32'(enable), 32'h0);
    tick(); tick();
    chk("f_finished", 32'(finished), 32'h1);
    chk("f_fail", 32'(fail), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_core_run_control.md
MULTI_CORE_RUN_CONTROL -- requirements
Module: multi_core_run_control

Interface
REQ-001 SHALL have parameter NUM_CORES, default 2, number of lockstep cores under control.
REQ-002 SHALL have parameter CNT_W, default 32, width of instruction budget and per-core counters.
REQ-003 SHALL have parameter WDOG_CYCLES, default 4096, number of retire-idle cycles before the run is declared failed.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port start_i  input  1  one-cycle run request; latches max_instr_i.
REQ-007 SHALL have port max_instr_i  input  CNT_W  per-core instruction budget.
REQ-008 SHALL have port fetch_i  input  NUM_CORES  per-core instruction-fetch strobe.
REQ-009 SHALL have port retire_i  input  NUM_CORES  per-core instruction-retire strobe.
REQ-010 SHALL have port enable_o  output  NUM_CORES  per-core fetch enable, registered.
REQ-011 SHALL have port busy_o  output  1  high in RUN or DRAIN.
REQ-012 SHALL have port finished_o  output  1  sticky; all cores retired exactly the budget.
REQ-013 SHALL have port fail_o  output  1  sticky; run aborted.
REQ-014 SHALL have port fail_cause_o  output  2  0 none, 1 watchdog, 2 retire overrun.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, FAIL.
REQ-016 IDLE/DONE/FAIL: start_i SHALL clear all counters, finished_o, fail_o and fail_cause_o, latch budget, enter RUN next cycle, and raise all enable_o bits in that same next cycle.
REQ-017 start_i in RUN or DRAIN SHALL be ignored.
REQ-018 Fetch counter c SHALL increment only when enable_o[c] and fetch_i[c] are both high; fetch_i with enable low SHALL be ignored.
REQ-019 enable_o[c] SHALL fall the cycle after the fetch that makes fetch count c equal the budget and stay low until the next start.
REQ-020 RUN SHALL move to DRAIN on the cycle after all enable_o bits are low.
REQ-021 Budget 0: enable_o SHALL stay low, FSM SHALL go RUN->DRAIN->DONE on consecutive cycles.
REQ-022 Retire counter c SHALL increment on retire_i[c] in RUN or DRAIN only; retire_i outside those states SHALL be ignored.
REQ-023 A retire with retire count c already equal to budget SHALL enter FAIL with cause 2; the counter SHALL not wrap.
REQ-024 DRAIN SHALL enter DONE when every retire count equals the budget; finished_o SHALL rise in the DONE entry cycle.
REQ-025 Watchdog SHALL reload on any retire_i bit or state entry, count in RUN/DRAIN, and enter FAIL with cause 1 after WDOG_CYCLES consecutive retire-free cycles.
REQ-026 Overrun and watchdog in the same cycle SHALL report cause 2.
REQ-027 Simultaneous fetch and retire on one core SHALL update both counters.
REQ-028 FAIL and DONE SHALL force enable_o low.

Reset
REQ-029 rst_i SHALL force IDLE, enable_o 0, busy_o 0, finished_o 0, fail_o 0, fail_cause_o 0, all counters and watchdog 0, budget 0.
REQ-030 rst_i mid-run SHALL take effect in the next cycle, overriding start_i.

Structure
REQ-031 FSM state enum and fail-cause encoding SHALL reside in package run_ctrl_pkg.
REQ-032 Per-core fetch/retire counters and enable SHALL be one sub-module core_budget_counter, instantiated NUM_CORES times by generate.

Verification
REQ-033 Budget 3, NUM_CORES 2, each core fetches and retires 3 -> enables fall after 3rd fetch, finished_o=1, fail_o=0.
REQ-034 Budget 4, core0 fetch_i held high 10 cycles -> exactly 4 fetches counted, enable_o[0] low from cycle 5 after start.
REQ-035 Budget 2, core1 retires 3 -> FAIL, fail_cause_o=2, enable_o=0.
REQ-036 WDOG_CYCLES 8, budget 2, no retires after start -> fail_o=1, cause 1, 8 cycles after RUN entry.
REQ-037 Budget 0 -> DONE two cycles after RUN entry, enable_o never high.
REQ-038 rst_i during DRAIN then start_i with budget 1 -> clean run, finished_o=1 after one fetch/retire per core.
